ex_mem_latch: RTL

EX/MEM pipeline register of the MIPS datapath: captures the execute-stage results and control at each clock edge and presents them to the memory stage. It directly feeds the MEM-stage branch AND gate (via `m_ctlout` and `zero`), data memory and the MEM/WB register. It supports stall (hold) and flush (bubble insertion), and keeps a saturating count of taken branches resolved in MEM.

---
 rtl/ex_mem_latch.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register with stall/flush and a saturating taken-branch counter.
// Optional build macro EX_MEM_BRANCH_SQUASH_EN: a taken branch squashes the EX entry behind it.
module ex_mem_latch #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             ex_valid,
    input  logic [1:0]       ctlwb_in,
    input  logic [2:0]       ctlm_in,
    input  logic [WIDTH-1:0] npc_target_in,
    input  logic             zero_in,
    input  logic [WIDTH-1:0] alu_result_in,
    input  logic [WIDTH-1:0] rdata2_in,
    input  logic [REG_W-1:0] dest_reg_in,
    output logic             mem_valid,
    output logic [1:0]       wb_ctlout,
    output logic             m_ctlout,
    output logic             mem_read,
    output logic             mem_write,
    output logic [WIDTH-1:0] add_result,
    output logic             zero,
    output logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] rdata2out,
    output logic [REG_W-1:0] five_bit_muxout,
    output logic [CNT_W-1:0] taken_count
);

    logic             valid_q, valid_d;
    logic [1:0]       wb_q, wb_d;
    logic             branch_q, branch_d;
    logic             mrd_q, mrd_d;
    logic             mwr_q, mwr_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] alu_q, alu_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [REG_W-1:0] dest_q, dest_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic taken;
    logic squash;
    logic bubble;

    assign taken = valid_q & branch_q & zero_q;

`ifdef EX_MEM_BRANCH_SQUASH_EN
    assign squash = taken;
`else
    assign squash = 1'b0;
`endif

    // Flush beats stall; an unstalled edge with no real instruction loads zeros.
    assign bubble = flush | (~stall & (squash | ~ex_valid));

    always_comb begin
        valid_d  = valid_q;
        wb_d     = wb_q;
        branch_d = branch_q;
        mrd_d    = mrd_q;
        mwr_d    = mwr_q;
        target_d = target_q;
        zero_d   = zero_q;
        alu_d    = alu_q;
        wdata_d  = wdata_q;
        dest_d   = dest_q;
        if (bubble) begin
            valid_d  = 1'b0;
            wb_d     = 2'b00;
            branch_d = 1'b0;
            mrd_d    = 1'b0;
            mwr_d    = 1'b0;
            target_d = '0;
            zero_d   = 1'b0;
            alu_d    = '0;
            wdata_d  = '0;
            dest_d   = '0;
        end else if (!stall) begin
            valid_d  = 1'b1;
            wb_d     = ctlwb_in;
            branch_d = ctlm_in[2];
            mrd_d    = ctlm_in[1];
            mwr_d    = ctlm_in[0];
            target_d = npc_target_in;
            zero_d   = zero_in;
            alu_d    = alu_result_in;
            wdata_d  = rdata2_in;
            dest_d   = dest_reg_in;
        end
    end

    // A held branch is counted once, on the edge it leaves the register.
    always_comb begin
        cnt_d = cnt_q;
        if (taken && !stall && !(&cnt_q)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            wb_q     <= 2'b00;
            branch_q <= 1'b0;
            mrd_q    <= 1'b0;
            mwr_q    <= 1'b0;
            target_q <= '0;
            zero_q   <= 1'b0;
            alu_q    <= '0;
            wdata_q  <= '0;
            dest_q   <= '0;
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            wb_q     <= wb_d;
            branch_q <= branch_d;
            mrd_q    <= mrd_d;
            mwr_q    <= mwr_d;
            target_q <= target_d;
            zero_q   <= zero_d;
            alu_q    <= alu_d;
            wdata_q  <= wdata_d;
            dest_q   <= dest_d;
            cnt_q    <= cnt_d;
        end
    end

    assign mem_valid       = valid_q;
    assign wb_ctlout       = wb_q;
    assign m_ctlout        = branch_q;
    assign mem_read        = mrd_q;
    assign mem_write       = mwr_q;
    assign add_result      = target_q;
    assign zero            = zero_q;
    assign alu_result      = alu_q;
    assign rdata2out       = wdata_q;
    assign five_bit_muxout = dest_q;
    assign taken_count     = cnt_q;

endmodule
